// File: rtl/cdc_fifo_sched_pkg.sv
// Shared types and constants for the CDC FIFO source-side scheduler.
package cdc_fifo_sched_pkg;

    localparam int unsigned TimeoutCntW = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_END   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_grant_sync.sv
// Round-robin grant with a lock that holds the winner stable until its handshake.
module rr_grant_sync #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NumReq-1:0] valid_i,
    input  logic              ready_i,
    output logic [IdxW-1:0]   grant_o,
    output logic              valid_o,
    output logic [NumReq-1:0] ready_o
);

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] search_idx;
    logic            lock_q, lock_d;
    logic            found;
    logic            hs;

    always_comb begin
        search_idx = rr_q;
        found      = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && valid_i[(int'(rr_q) + k) % NumReq]) begin
                found      = 1'b1;
                search_idx = IdxW'((int'(rr_q) + k) % NumReq);
            end
        end
    end

    assign grant_o = lock_q ? lock_idx_q : search_idx;
    assign valid_o = en_i & valid_i[grant_o];
    assign hs      = valid_o & ready_i;
    // Disabling (clear sequence) forces valid_o low, which also drops the lock.
    assign lock_d  = valid_o & ~ready_i;

    always_comb begin
        ready_o = '0;
        if (en_i) ready_o[grant_o] = ready_i;
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (grant_o == IdxW'(NumReq - 1)) ? '0 : grant_o + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= grant_o;
        end
    end

endmodule

// File: rtl/cdc_fifo_src_scheduler.sv
// Shares a CDC FIFO source port among requesters and sequences FIFO clears with a timeout.
module cdc_fifo_src_scheduler
    import cdc_fifo_sched_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter type         T             = logic [31:0],
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  T     [NumReq-1:0]   req_data_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  logic                clear_req_i,
    output logic                clear_busy_o,
    output logic                clear_timeout_o,
    output logic                fifo_clear_o,
    input  logic                fifo_clear_pending_i,
    output T                    fifo_data_o,
    output logic                fifo_valid_o,
    input  logic                fifo_ready_i
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam logic [TimeoutCntW-1:0] CntLast = TimeoutCntW'(TimeoutCycles - 1);

    sched_state_e            state_q, state_d;
    logic [TimeoutCntW-1:0]  cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    in_idle;
    logic                    arb_en;
    logic [IdxW-1:0]         grant;

    assign in_idle = (state_q == ST_IDLE);
    // A clear request wins over arbitration in the same cycle; reset gates everything.
    assign arb_en  = in_idle & ~clear_req_i & ~rst_i;

    rr_grant_sync #(.NumReq(NumReq)) u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arb_en),
        .valid_i (req_valid_i),
        .ready_i (fifo_ready_i),
        .grant_o (grant),
        .valid_o (fifo_valid_o),
        .ready_o (req_ready_o)
    );

    assign fifo_data_o     = req_data_i[grant];
    assign fifo_clear_o    = (state_q == ST_ISSUE) & ~rst_i;
    assign clear_busy_o    = ~in_idle & ~rst_i;
    assign clear_timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d   = ST_ISSUE;
                    timeout_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_START;
                cnt_d   = '0;
            end
            ST_WAIT_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (fifo_clear_pending_i) begin
                    state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                cnt_d = cnt_q + 1'b1;
                // A clean finish on the last counted cycle is not a timeout.
                if (!fifo_clear_pending_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CntLast) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_src_scheduler.sv
// Directed bench: a 4-requester instance with default timeout, and a 3-requester one with a short timeout.
module tb_cdc_fifo_src_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]        a_valid, a_ready_o;
    logic [3:0][31:0]  a_data;
    logic              a_clear_req, a_busy, a_to, a_fclr, a_pend, a_fvalid, a_fready;
    logic [31:0]       a_fdata;

    logic [2:0]        b_valid, b_ready_o;
    logic [2:0][31:0]  b_data;
    logic              b_clear_req, b_busy, b_to, b_fclr, b_pend, b_fvalid, b_fready;
    logic [31:0]       b_fdata;

    int n_checks = 0;
    int n_err    = 0;

    cdc_fifo_src_scheduler #(.NumReq(4), .T(logic [31:0]), .TimeoutCycles(255)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_valid), .req_data_i(a_data), .req_ready_o(a_ready_o),
        .clear_req_i(a_clear_req), .clear_busy_o(a_busy), .clear_timeout_o(a_to),
        .fifo_clear_o(a_fclr), .fifo_clear_pending_i(a_pend),
        .fifo_data_o(a_fdata), .fifo_valid_o(a_fvalid), .fifo_ready_i(a_fready)
    );

    cdc_fifo_src_scheduler #(.NumReq(3), .T(logic [31:0]), .TimeoutCycles(10)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_data_i(b_data), .req_ready_o(b_ready_o),
        .clear_req_i(b_clear_req), .clear_busy_o(b_busy), .clear_timeout_o(b_to),
        .fifo_clear_o(b_fclr), .fifo_clear_pending_i(b_pend),
        .fifo_data_o(b_fdata), .fifo_valid_o(b_fvalid), .fifo_ready_i(b_fready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        a_valid = '0; a_clear_req = 0; a_pend = 0; a_fready = 0;
        b_valid = '0; b_clear_req = 0; b_pend = 0; b_fready = 0;
        for (int i = 0; i < 4; i++) a_data[i] = 32'hA0 + i;
        for (int i = 0; i < 3; i++) b_data[i] = 32'hB0 + i;
        tick(); tick();

        // reset state, with requests pending
        a_valid = 4'hF; a_fready = 1; b_valid = 3'b111; b_fready = 1; #1;
        chk("rst_a_fvalid", a_fvalid, 0);
        chk("rst_a_ready", a_ready_o, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_fclr", a_fclr, 0);
        chk("rst_a_timeout", a_to, 0);
        chk("rst_b_ready", b_ready_o, 0);
        b_valid = '0;
        rst = 1'b0; #1;

        // round-robin with everyone valid
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_seq%0d_ready", i), a_ready_o, rr_exp[i]);
            chk($sformatf("rr_seq%0d_data", i), a_fdata, 32'hA0 + (i % 4));
            tick();
        end

        // lock on requester 2 while the FIFO stalls
        a_valid = 4'b0100; a_fready = 0; #1;
        chk("lock_fvalid", a_fvalid, 1);
        chk("lock_data", a_fdata, 32'hA2);
        chk("lock_ready", a_ready_o, 0);
        tick();
        a_valid = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("lock_hold%0d_data", i), a_fdata, 32'hA2);
            chk($sformatf("lock_hold%0d_valid", i), a_fvalid, 1);
            tick();
        end
        a_fready = 1; #1;
        chk("lock_hs_ready", a_ready_o, 4'b0100);
        tick();
        chk("rr_after_lock", a_ready_o, 4'b1000);
        chk("rr_after_lock_data", a_fdata, 32'hA3);
        tick();
        chk("rr_wrap_skip0", a_ready_o, 4'b0010);
        tick();

        // clear sequence: pending rises 3 cycles after the pulse, falls 6 later
        a_valid = 4'hF; a_clear_req = 1; #1;
        chk("clr_prio_fvalid", a_fvalid, 0);
        chk("clr_prio_ready", a_ready_o, 0);
        chk("clr_prio_busy", a_busy, 0);
        tick();
        a_clear_req = 0; #1;
        chk("issue_fclr", a_fclr, 1);
        chk("issue_busy", a_busy, 1);
        chk("issue_fvalid", a_fvalid, 0);
        chk("issue_ready", a_ready_o, 0);
        tick();
        for (int c = 1; c <= 9; c++) begin
            a_pend = (c >= 3 && c <= 8);
            a_clear_req = (c == 5);
            #1;
            chk($sformatf("clr_c%0d_fclr", c), a_fclr, 0);
            chk($sformatf("clr_c%0d_busy", c), a_busy, 1);
            chk($sformatf("clr_c%0d_ready", c), a_ready_o, 0);
            tick();
        end
        a_clear_req = 0; a_pend = 0; #1;
        chk("clr_done_busy", a_busy, 0);
        chk("clr_done_timeout", a_to, 0);
        chk("clr_done_fclr", a_fclr, 0);
        chk("rr_preserved", a_ready_o, 4'b0100);
        tick();

        // remote clear pending while idle does not disturb arbitration
        a_pend = 1; #1;
        chk("remote_busy", a_busy, 0);
        chk("remote_ready", a_ready_o, 4'b1000);
        tick();
        chk("remote_ready2", a_ready_o, 4'b0001);
        chk("remote_fclr", a_fclr, 0);
        tick();

        // reset while waiting for the clear to end
        a_pend = 0; a_valid = '0; a_clear_req = 1; #1;
        tick();
        a_clear_req = 0;
        tick();
        a_pend = 1;
        tick();
        chk("wend_busy", a_busy, 1);
        rst = 1; #1;
        chk("rst_mid_fclr", a_fclr, 0);
        chk("rst_mid_busy", a_busy, 0);
        chk("rst_mid_fvalid", a_fvalid, 0);
        tick();
        rst = 0; #1;
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_fclr", a_fclr, 0);
        chk("post_rst_timeout", a_to, 0);
        tick();
        chk("post_rst_fclr2", a_fclr, 0);
        chk("post_rst_busy2", a_busy, 0);
        a_pend = 0; a_valid = 4'hF; #1;
        chk("rr_reset", a_ready_o, 4'b0001);
        a_valid = '0;
        tick();

        // three requesters: wrap from 2 back to 0
        b_valid = 3'b100; b_fready = 1; #1;
        chk("b_grant2", b_ready_o, 3'b100);
        chk("b_grant2_data", b_fdata, 32'hB2);
        tick();
        b_valid = 3'b111; #1;
        chk("b_wrap", b_ready_o, 3'b001);
        chk("b_wrap_data", b_fdata, 32'hB0);

        // timeout with pending never rising
        b_valid = '0; b_clear_req = 1; #1;
        tick();
        b_clear_req = 0; #1;
        chk("b_issue_fclr", b_fclr, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("b_wait%0d_busy", k), b_busy, 1);
            chk($sformatf("b_wait%0d_timeout", k), b_to, 0);
            tick();
        end
        chk("b_to_set", b_to, 1);
        chk("b_to_idle", b_busy, 0);
        tick(); tick();
        chk("b_to_sticky", b_to, 1);
        b_clear_req = 1; #1;
        chk("b_to_hold", b_to, 1);
        tick();
        b_clear_req = 0; #1;
        chk("b_to_cleared", b_to, 0);
        chk("b_reissue_busy", b_busy, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
